flash_programmer: RTL
=====================

# flash_programmer

Command sequencer upstream of the external memory controller's flash write and read ports. It turns single high-level requests into the multi-cycle JEDEC command bus cycles the NOR flash needs: unlock sequence, program, sector erase, chip erase and reset-to-read-array. It then waits for the device to finish and verifies the result by reading it back. It drives only the controller's flash request and address/data inputs; all pin-level timing stays in the controller.

## Interface
Parameters:
- CMD_ADDR_A, 20'h00AAA, first unlock/command address (byte mode).
- CMD_ADDR_B, 20'h00555, second unlock address.
- SETTLE_CYCLES, 4, wait after the last command write before sampling ry_by (covers tBUSY).
- TIMEOUT_CYCLES, 28'd200_000_000, maximum wait for ry_by high (5 s at 40 MHz).

Ports:
- CLK_40  in  1  system clock, 40 MHz.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  operation: 0 program byte, 1 sector erase, 2 chip erase, 3 reset (F0).
- cmd_addr  in  20  target byte address (program) or sector address (sector erase).
- cmd_data  in  8  byte to program.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when the command completes.
- error  out  1  result of the last command: timeout or verify mismatch; valid with done.
- fl_wr_req  out  1  to controller flash_write_req.
- fl_wr_addr  out  20  to controller flash_write_address.
- fl_wr_data  out  8  to controller flash_write_data.
- fl_wr_idle  in  1  from controller flash_write_idle.
- fl_rd_req  out  1  to controller flash_read_req.
- fl_rd_addr  out  20  to controller flash_read_address.
- fl_rd_data  in  8  from controller flash_read_data.
- fl_rd_idle  in  1  from controller flash_read_idle.
- flash_ry_by  in  1  device ready/busy pin; asynchronous; high means ready.

## Operation
- flash_ry_by passes through a 2-flop synchroniser to give ryby_s; both flops reset to 0.
- cmd_ready = (state==IDLE) && ryby_s. The command is accepted when cmd_valid && cmd_ready; op, addr and data are latched at acceptance.
- Bus-cycle sequences, as address<-data:
  - Program: A<-AA, B<-55, A<-A0, addr<-data.
  - Sector erase: A<-AA, B<-55, A<-80, A<-AA, B<-55, addr<-30.
  - Chip erase: as sector erase, but the last cycle is A<-10.
  - Reset: addr<-F0.
- States:
  - IDLE: on accept, set step to 0 and go to WR_REQ.
  - WR_REQ: assert fl_wr_req with the step's addr/data; go to WR_WAIT when fl_wr_idle==0.
  - WR_WAIT: when fl_wr_idle==1, drop fl_wr_req in that same cycle. If this was not the last step, increment step and go to WR_REQ. If it was the last step, go to SETTLE, or to FINISH when op==3.
  - SETTLE: count SETTLE_CYCLES, then go to BUSY_WAIT.
  - BUSY_WAIT: go to VERIFY_REQ when ryby_s==1. When the timeout counter reaches TIMEOUT_CYCLES, set err_flag and go to RECOVER.
  - VERIFY_REQ / VERIFY_WAIT: perform the same handshake on the read port at the latched addr. On completion, compare fl_rd_data with the expected value: data for program, 8'hFF for either erase. A mismatch sets err_flag. Then go to FINISH.
  - RECOVER: issue a single addr<-F0 write using the write handshake, then go to FINISH.
  - FINISH: pulse done, set error from err_flag, return to IDLE.
- error holds until the next accept, where it clears to 0.
- fl_wr_req and fl_rd_req are never asserted together.

## Timing
- Reset values: fl_wr_req=0, fl_rd_req=0, fl_wr_addr=0, fl_wr_data=0, fl_rd_addr=0, busy=0, done=0, error=0, cmd_ready=0. cmd_ready rises 2 cycles after reset release if flash_ry_by is high.
- busy rises the cycle after accept and falls together with the done pulse.
- Each bus cycle takes one controller round trip; no write is issued while fl_wr_idle is 0.
- Request rule: hold req until idle has been seen 0 and then 1; drop req in the cycle idle is seen 1.
- Reset mid-operation: return to IDLE at once and drop both reqs. The flash may still be busy, so cmd_ready stays 0 until ryby_s is 1.
- The timeout counter is 28 bits, clears on entry to SETTLE, and saturates.
- cmd_valid during busy is ignored, and the command is not queued.

## Structure
- Shared package flash_pkg holds: the op encodings, the command bytes (AA, 55, A0, 80, 30, 10, F0), and the state encoding.
- Sub-module flash_cmd_rom is combinational. It maps (op, step, latched addr/data) to (addr, data, last). It holds the sequence tables only, with no state.

## Test plan
- Program op at 0x12345, data 0x5A; ry_by low for 100 cycles; readback 0x5A. Required: write addr/data pairs AAA/AA, 555/55, AAA/A0, 12345/5A; read request at 0x12345; done pulse with error=0.
- Sector erase at 0x20000; readback 0xFF. Required: 6 writes ending with 20000/30; error=0.
- Program data 0x00 with readback 0x01. Required: done with error=1; error clears on the next accept.
- ry_by held low, with TIMEOUT_CYCLES set to 1000. Required: after about 1000 cycles an F0 write is issued, then done with error=1.
- Reset asserted during the third write of a chip erase while ry_by is low. Required: both reqs are 0 immediately; cmd_ready stays 0 until 2 cycles after ry_by goes high.
- Controller that keeps idle low for 0 to 7 random cycles per request. Required: each sequence still completes with the correct pairs; wr_req and rd_req are never both asserted.

Source files
------------

// File: rtl/flash_pkg.sv
// flash_pkg: operation codes, JEDEC command bytes and sequencer state encoding
package flash_pkg;
  typedef enum logic [1:0] {OP_PROG = 2'd0, OP_SECTOR = 2'd1, OP_CHIP = 2'd2, OP_RESET = 2'd3} op_e;
  localparam logic [7:0] CMD_AA = 8'hAA;
  localparam logic [7:0] CMD_55 = 8'h55;
  localparam logic [7:0] CMD_A0 = 8'hA0;
  localparam logic [7:0] CMD_80 = 8'h80;
  localparam logic [7:0] CMD_30 = 8'h30;
  localparam logic [7:0] CMD_10 = 8'h10;
  localparam logic [7:0] CMD_F0 = 8'hF0;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_SETTLE, S_BUSY_WAIT,
    S_VERIFY_REQ, S_VERIFY_WAIT, S_RECOVER, S_FINISH
  } state_e;
endpackage

// File: rtl/flash_if.sv
// flash_if: programmer <-> memory controller flash write/read request ports
//   master (programmer): drives wr_req/wr_addr/wr_data and rd_req/rd_addr
//   slave (controller):  drives wr_idle, rd_idle and rd_data
interface flash_if;
  logic        wr_req, wr_idle, rd_req, rd_idle;
  logic [19:0] wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data;
  modport master(output wr_req, wr_addr, wr_data, rd_req, rd_addr, input wr_idle, rd_data, rd_idle);
  modport slave(input wr_req, wr_addr, wr_data, rd_req, rd_addr, output wr_idle, rd_data, rd_idle);
endinterface

// File: rtl/flash_cmd_rom.sv
// flash_cmd_rom: combinational JEDEC bus-cycle tables
//   in:  op, step, latched addr/data
//   out: wr_addr/wr_data for this step, last = final step of the sequence
module flash_cmd_rom
  import flash_pkg::*;
#(
  parameter logic [19:0] CMD_ADDR_A = 20'h00AAA,
  parameter logic [19:0] CMD_ADDR_B = 20'h00555
) (
  input  op_e         op,
  input  logic [2:0]  step,
  input  logic [19:0] addr,
  input  logic [7:0]  data,
  output logic [19:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        last
);
  logic prog, chip;
  assign prog = op == OP_PROG;
  assign chip = op == OP_CHIP;
  // Program and both erases share the AA/55 unlock; erases repeat it after 80.
  always_comb begin
    wr_addr = CMD_ADDR_A;
    wr_data = CMD_AA;
    last = 1'b0;
    if (op == OP_RESET) begin
      wr_addr = addr;
      wr_data = CMD_F0;
      last = 1'b1;
    end else case (step)
      3'd0: wr_data = CMD_AA;
      3'd1, 3'd4: begin
        wr_addr = CMD_ADDR_B;
        wr_data = CMD_55;
      end
      3'd2: wr_data = prog ? CMD_A0 : CMD_80;
      3'd3: begin
        wr_addr = prog ? addr : CMD_ADDR_A;
        wr_data = prog ? data : CMD_AA;
        last = prog;
      end
      default: begin
        wr_addr = chip ? CMD_ADDR_A : addr;
        wr_data = chip ? CMD_10 : CMD_30;
        last = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/flash_programmer.sv
// flash_programmer: turns program/erase/reset requests into JEDEC bus cycles,
// waits for ry_by, verifies by readback, recovers with F0 on timeout.
//   CLK_40, reset (async, active-high)
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data: command request
//   busy, done (1-cycle pulse), error (valid with done, held until next accept)
//   flash_ry_by: async device ready pin
//   fl: write/read request ports towards the memory controller
module flash_programmer
  import flash_pkg::*;
#(
  parameter logic [19:0] CMD_ADDR_A     = 20'h00AAA,
  parameter logic [19:0] CMD_ADDR_B     = 20'h00555,
  parameter int          SETTLE_CYCLES  = 4,
  parameter logic [27:0] TIMEOUT_CYCLES = 28'd200_000_000
) (
  input  logic        CLK_40,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [19:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        flash_ry_by,
  flash_if.master     fl
);
  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [2:0]  step_q, step_d;
  logic [19:0] addr_q, addr_d, rom_addr;
  logic [7:0]  data_q, data_d, rom_data, expected;
  logic [27:0] tmo_q, tmo_d, tmo_inc;
  logic        err_flag_q, err_flag_d, error_q, error_d;
  logic        ry_meta_q, ryby_s_q, rom_last, wr_req, rd_req;
  flash_cmd_rom #(.CMD_ADDR_A(CMD_ADDR_A), .CMD_ADDR_B(CMD_ADDR_B)) u_rom (
    .op(op_q), .step(step_q), .addr(addr_q), .data(data_q),
    .wr_addr(rom_addr), .wr_data(rom_data), .last(rom_last)
  );
  assign cmd_ready = state_q == S_IDLE && ryby_s_q;
  assign busy = state_q != S_IDLE && state_q != S_FINISH;
  assign done = state_q == S_FINISH;
  assign error = done ? err_flag_q : error_q;
  assign expected = op_q == OP_PROG ? data_q : 8'hFF;
  assign tmo_inc = &tmo_q ? tmo_q : tmo_q + 28'd1;
  // Address/data are zeroed outside a request so the controller never sees stale values.
  assign fl.wr_req = wr_req;
  assign fl.wr_addr = wr_req ? rom_addr : '0;
  assign fl.wr_data = wr_req ? rom_data : '0;
  assign fl.rd_req = rd_req;
  assign fl.rd_addr = rd_req ? addr_q : '0;
  always_ff @(posedge CLK_40 or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= OP_PROG;
      step_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      tmo_q <= '0;
      err_flag_q <= 1'b0;
      error_q <= 1'b0;
      ry_meta_q <= 1'b0;
      ryby_s_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      step_q <= step_d;
      addr_q <= addr_d;
      data_q <= data_d;
      tmo_q <= tmo_d;
      err_flag_q <= err_flag_d;
      error_q <= error_d;
      ry_meta_q <= flash_ry_by;
      ryby_s_q <= ry_meta_q;
    end
  // Requests drop combinationally in the cycle idle returns high, so the
  // controller never sees req && idle at the completing edge.
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    step_d = step_q;
    addr_d = addr_q;
    data_d = data_q;
    tmo_d = tmo_q;
    err_flag_d = err_flag_q;
    error_d = error_q;
    wr_req = 1'b0;
    rd_req = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid && cmd_ready) begin
        op_d = op_e'(cmd_op);
        addr_d = cmd_addr;
        data_d = cmd_data;
        step_d = '0;
        err_flag_d = 1'b0;
        error_d = 1'b0;
        state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        wr_req = 1'b1;
        state_d = fl.wr_idle ? S_WR_REQ : S_WR_WAIT;
      end
      S_WR_WAIT: begin
        wr_req = !fl.wr_idle;
        if (fl.wr_idle) begin
          step_d = step_q + 3'd1;
          tmo_d = '0;
          state_d = !rom_last ? S_WR_REQ : op_q == OP_RESET ? S_FINISH : S_SETTLE;
        end
      end
      S_SETTLE: begin
        tmo_d = tmo_inc;
        state_d = tmo_q == 28'(SETTLE_CYCLES - 1) ? S_BUSY_WAIT : S_SETTLE;
      end
      S_BUSY_WAIT: begin
        tmo_d = tmo_inc;
        if (ryby_s_q) state_d = S_VERIFY_REQ;
        else if (tmo_q >= TIMEOUT_CYCLES) begin
          err_flag_d = 1'b1;
          state_d = S_RECOVER;
        end
      end
      S_VERIFY_REQ: begin
        rd_req = 1'b1;
        state_d = fl.rd_idle ? S_VERIFY_REQ : S_VERIFY_WAIT;
      end
      S_VERIFY_WAIT: begin
        rd_req = !fl.rd_idle;
        if (fl.rd_idle) begin
          err_flag_d = err_flag_q | (fl.rd_data != expected);
          state_d = S_FINISH;
        end
      end
      // Recovery reuses the reset-op table entry: a single addr<-F0 write, then finish.
      S_RECOVER: begin
        op_d = OP_RESET;
        step_d = '0;
        state_d = S_WR_REQ;
      end
      S_FINISH: begin
        error_d = err_flag_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
